// File: rtl/icon_scb_sched.sv
// rtl/icon_scb_sched.sv - slot-table sequencer driving the switch-control word of the icon tree
// Optional feature: define ICON_SCHED_SKIP_EN to skip slots whose entry-valid bit is clear.
module icon_scb_sched #(
  parameter int CHANS = 4,
  parameter int SLOTS = 8,
  localparam int STAGES = $clog2(4*CHANS),
  localparam int NODES  = 2*CHANS,
  localparam int SW     = $clog2(SLOTS)
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_cfg_we,
  input  logic [SW-1:0]                 i_cfg_addr,
  input  logic [STAGES-1:0][NODES-1:0]  i_cfg_scb,
  input  logic                          i_cfg_vld,
  input  logic [SW-1:0]                 i_period,
  input  logic                          i_start,
  input  logic                          i_stop,
  output logic [STAGES-1:0][NODES-1:0]  o_scb,
  output logic [SW-1:0]                 o_slot,
  output logic                          o_frame,
  output logic                          o_busy,
  output logic                          o_cfg_err
);

  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;
  typedef logic [STAGES-1:0][NODES-1:0] scb_t;

  state_t           state_q, state_d;
  scb_t             tbl_scb [SLOTS];
  logic [SLOTS-1:0] tbl_vld;
  logic             tbl_we;

  logic [SW-1:0]    period_q, period_d;
  logic [SW-1:0]    slot_d, next_slot, first_slot;
  logic             last_slot;
  scb_t             scb_d, first_word, next_word;
  logic             frame_d, busy_d, err_d;

  // Invalid entries always present an all-zero word, whether visited or not.
  assign first_word = tbl_vld[first_slot] ? tbl_scb[first_slot] : '0;
  assign next_word  = tbl_vld[next_slot]  ? tbl_scb[next_slot]  : '0;

`ifdef ICON_SCHED_SKIP_EN
  // Downward scans leave the lowest qualifying index; with no valid slot the frame collapses to slot 0.
  always_comb begin
    next_slot  = '0;
    last_slot  = 1'b1;
    first_slot = '0;
    for (int i = SLOTS-1; i >= 0; i--) begin
      if (tbl_vld[i] && (SW'(i) > o_slot) && (SW'(i) <= period_q)) begin
        next_slot = SW'(i);
        last_slot = 1'b0;
      end
      if (tbl_vld[i] && (SW'(i) <= i_period)) begin
        first_slot = SW'(i);
      end
    end
  end
`else
  assign next_slot  = o_slot + SW'(1);
  assign last_slot  = (o_slot == period_q);
  assign first_slot = '0;
`endif

  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    slot_d   = o_slot;
    scb_d    = o_scb;
    frame_d  = 1'b0;
    busy_d   = o_busy;
    err_d    = 1'b0;
    tbl_we   = 1'b0;
    case (state_q)
      IDLE: begin
        tbl_we = i_cfg_we;
        slot_d = '0;
        scb_d  = '0;
        busy_d = 1'b0;
        if (i_start && !i_stop) begin
          state_d  = RUN;
          period_d = i_period;
          slot_d   = first_slot;
          scb_d    = first_word;
          frame_d  = 1'b1;
          busy_d   = 1'b1;
        end
      end
      RUN, STOPPING: begin
        err_d = i_cfg_we;
        if (last_slot) begin
          // A stop seen on the last slot of a frame has nothing left to finish.
          if (state_q == STOPPING || i_stop) begin
            state_d = IDLE;
            slot_d  = '0;
            scb_d   = '0;
            busy_d  = 1'b0;
          end else begin
            period_d = i_period;
            slot_d   = first_slot;
            scb_d    = first_word;
            frame_d  = 1'b1;
          end
        end else begin
          slot_d = next_slot;
          scb_d  = next_word;
          if (i_stop) state_d = STOPPING;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      period_q  <= '0;
      o_scb     <= '0;
      o_slot    <= '0;
      o_frame   <= 1'b0;
      o_busy    <= 1'b0;
      o_cfg_err <= 1'b0;
      tbl_vld   <= '0;
      for (int i = 0; i < SLOTS; i++) tbl_scb[i] <= '0;
    end else begin
      state_q   <= state_d;
      period_q  <= period_d;
      o_scb     <= scb_d;
      o_slot    <= slot_d;
      o_frame   <= frame_d;
      o_busy    <= busy_d;
      o_cfg_err <= err_d;
      if (tbl_we) begin
        tbl_vld[i_cfg_addr] <= i_cfg_vld;
        tbl_scb[i_cfg_addr] <= i_cfg_scb;
      end
    end
  end

endmodule

// File: tb/tb_icon_scb_sched.sv
// tb/tb_icon_scb_sched.sv - randomized bench for icon_scb_sched against a frame-queue model
// Build with ICON_SCHED_SKIP_EN defined to check the slot-skipping variant.
module tb_icon_scb_sched;

  localparam int CHANS  = 4;
  localparam int SLOTS  = 8;
  localparam int STAGES = $clog2(4*CHANS);
  localparam int NODES  = 2*CHANS;
  localparam int SW     = $clog2(SLOTS);

  typedef logic [STAGES-1:0][NODES-1:0] scb_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_we, cfg_vld, start, stop;
  logic [SW-1:0] cfg_addr, period;
  scb_t          cfg_scb;
  scb_t          scb;
  logic [SW-1:0] slot;
  logic          frame, busy, cfg_err;

  int n_cmp = 0;
  int n_err = 0;

  icon_scb_sched #(.CHANS(CHANS), .SLOTS(SLOTS)) dut (
    .i_clk(clk), .i_rst(rst), .i_cfg_we(cfg_we), .i_cfg_addr(cfg_addr),
    .i_cfg_scb(cfg_scb), .i_cfg_vld(cfg_vld), .i_period(period),
    .i_start(start), .i_stop(stop), .o_scb(scb), .o_slot(slot),
    .o_frame(frame), .o_busy(busy), .o_cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic ck(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: a frame is the list of slots it will visit, consumed one per cycle.
  scb_t m_scb [SLOTS];
  bit   m_vld [SLOTS];
  int   m_q[$];
  bit   m_run, m_stopping;
  scb_t e_scb;
  int   e_slot;
  bit   e_frame, e_busy, e_err;

  function automatic void build_frame(input int per);
    m_q.delete();
`ifdef ICON_SCHED_SKIP_EN
    for (int s = 0; s <= per; s++) if (m_vld[s]) m_q.push_back(s);
    if (m_q.size() == 0) m_q.push_back(0);
`else
    for (int s = 0; s <= per; s++) m_q.push_back(s);
`endif
  endfunction

  function automatic void show_next(input bit first);
    int s;
    s = m_q.pop_front();
    e_slot  = s;
    e_scb   = m_vld[s] ? m_scb[s] : '0;
    e_frame = first;
  endfunction

  function automatic void go_idle();
    m_run = 0; m_stopping = 0; m_q.delete();
    e_slot = 0; e_scb = '0; e_frame = 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SLOTS; s++) begin m_vld[s] = 0; m_scb[s] = '0; end
      go_idle();
      e_busy = 0; e_err = 0;
    end else begin
      e_err = m_run && cfg_we;
      if (!m_run) begin
        e_frame = 0; e_slot = 0; e_scb = '0;
        if (start && !stop) begin
          m_run = 1; m_stopping = 0;
          build_frame(int'(period));
          show_next(1);
        end
        if (cfg_we) begin m_vld[cfg_addr] = cfg_vld; m_scb[cfg_addr] = cfg_scb; end
      end else if (m_q.size() == 0) begin
        if (m_stopping || stop) go_idle();
        else begin build_frame(int'(period)); show_next(1); end
      end else begin
        show_next(0);
        if (stop) m_stopping = 1;
      end
      e_busy = m_run;
    end
  end

  always @(negedge clk) begin
    ck("scb", scb, e_scb);
    ck("slot", slot, e_slot);
    ck("frame", frame, e_frame);
    ck("busy", busy, e_busy);
    ck("cfg_err", cfg_err, e_err);
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic wr(input int a, input scb_t w, input bit v);
    cfg_we = 1; cfg_addr = SW'(a); cfg_scb = w; cfg_vld = v;
    cyc();
    cfg_we = 0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy === 1'b1 && k < 40) begin cyc(); k++; end
    ck("idle_reached", busy, 0);
  endtask

  int   exp_slot [4];
  scb_t exp_word [4];
  int   r;

  initial begin
    rst = 1; cfg_we = 0; cfg_vld = 0; cfg_addr = '0; cfg_scb = '0;
    period = '0; start = 0; stop = 0;
    repeat (2) cyc();
    rst = 0;
    ck("rst_scb", scb, 0); ck("rst_slot", slot, 0); ck("rst_busy", busy, 0);
    ck("rst_frame", frame, 0); ck("rst_err", cfg_err, 0);

    for (int k = 0; k < 4; k++) wr(k, scb_t'((k+1) * 32'h11), 1);

    period = 3; start = 1; cyc(); start = 0;
    ck("t1_scb0", scb, 32'h11); ck("t1_slot0", slot, 0);
    ck("t1_frame0", frame, 1); ck("t1_busy0", busy, 1); ck("model_pin_scb", e_scb, 32'h11);
    cyc(); ck("t1_slot1", slot, 1); ck("t1_scb1", scb, 32'h22); ck("t1_frame1", frame, 0);
    cyc(); ck("t1_slot2", slot, 2);
    cyc(); ck("t1_scb3", scb, 32'h44);
    cyc(); ck("t1_wrap_frame", frame, 1); ck("t1_wrap_slot", slot, 0);
    cyc(); cyc(); ck("t2_at_slot2", slot, 2);
    stop = 1; cyc(); stop = 0;
    ck("t2_slot3", slot, 3); ck("t2_scb3", scb, 32'h44); ck("t2_busy3", busy, 1);
    cyc(); ck("t2_busy_off", busy, 0); ck("t2_scb_off", scb, 0); ck("t2_slot_off", slot, 0);

    start = 1; cyc(); start = 0;
    wr(1, scb_t'(32'hdead), 0);
    ck("t3_err_pulse", cfg_err, 1);
    cyc(); ck("t3_err_once", cfg_err, 0);
    stop = 1; cyc(); stop = 0; wait_idle();
    period = 1; start = 1; cyc(); start = 0;
    stop = 1; cyc(); stop = 0;
    ck("t3_readback_slot", slot, 1); ck("t3_readback_scb", scb, 32'h22);
    cyc(); ck("t3_idle", busy, 0);

    wr(1, scb_t'(32'h99), 0);
`ifdef ICON_SCHED_SKIP_EN
    exp_slot = '{0, 2, 3, 0};
    exp_word = '{scb_t'(32'h11), scb_t'(32'h33), scb_t'(32'h44), scb_t'(32'h11)};
`else
    exp_slot = '{0, 1, 2, 3};
    exp_word = '{scb_t'(32'h11), scb_t'(0), scb_t'(32'h33), scb_t'(32'h44)};
`endif
    period = 3; start = 1; cyc(); start = 0;
    for (int i = 0; i < 4; i++) begin
      ck("t4_slot", slot, exp_slot[i]); ck("t4_scb", scb, exp_word[i]);
      cyc();
    end
    stop = 1; cyc(); stop = 0; wait_idle();

    start = 1; stop = 1; cyc(); start = 0; stop = 0;
    ck("t5_busy", busy, 0); ck("t5_slot", slot, 0);
    cyc(); ck("t5_busy_hold", busy, 0);

    wr(1, scb_t'(32'h22), 1);
    period = 3; start = 1; cyc(); start = 0;
    cyc(); cyc(); ck("t6_at_slot2", slot, 2);
    #2 rst = 1;
    #1 ck("t6_async_scb", scb, 0); ck("t6_async_slot", slot, 0); ck("t6_async_busy", busy, 0);
    ck("t6_async_frame", frame, 0); ck("t6_async_err", cfg_err, 0);
    cyc(); rst = 0;
    period = 3; start = 1; cyc(); start = 0;
    ck("t6_cleared_scb", scb, 0); ck("t6_restart_busy", busy, 1); ck("t6_restart_slot", slot, 0);
    stop = 1; cyc(); stop = 0; wait_idle();

    for (int n = 0; n < 4000; n++) begin
      cfg_we = 0; start = 0; stop = 0;
      period = SW'($urandom_range(0, SLOTS-1));
      r = $urandom_range(0, 999);
      if (r < 3) begin
        #2 rst = 1;
        #1 ck("rnd_async_busy", busy, 0); ck("rnd_async_scb", scb, 0);
        cyc(); rst = 0;
        continue;
      end
      r = $urandom_range(0, 99);
      if (r < 12) begin
        cfg_we = 1; cfg_addr = SW'($urandom_range(0, SLOTS-1));
        cfg_scb = scb_t'($urandom); cfg_vld = ($urandom_range(0, 3) != 0);
      end else if (r < 22) start = 1;
      else if (r < 26) stop = 1;
      else if (r < 28) begin start = 1; stop = 1; end
      cyc();
    end
    cfg_we = 0; start = 0; stop = 0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
